regfile_2r1w_init: RTL and testbench

- Parametrised two-read, one-write register file for the RISC datapath; next generation of the 32x16 register file.
- Width, depth and an optional hardwired zero register are set by parameters.
- All accesses are on the rising edge of clk; there is no negedge write.
- Adds a hardware clear engine after reset and on request, per-port read-valid flags, and dropped-write reporting.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_fsm.sv | 51 +++++
 rtl/regfile_2r1w_init.sv | 94 +++++++++
 tb/tb_regfile_2r1w_init.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the two-read, one-write register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_RD     = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks every entry after reset or on request; owns the array
// write port while clearing.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              ready,
  output logic              clear_sel,
  output logic [ADDR_W-1:0] clear_idx
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state     <= state_nxt;
      clear_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clear_idx;
    case (state)
      CLEAR: begin
        // Counter wraps to 0 on the last entry, leaving it ready for a later clear.
        idx_nxt = clear_idx + ADDR_W'(1);
        if (clear_idx == '1) state_nxt = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready     = (state == IDLE);
  assign clear_sel = (state == CLEAR);

endmodule

// File: rtl/regfile_2r1w_init.sv
// Parametrised 2R1W register file with post-reset clear engine.
// Define REGFILE_BYPASS_EN for write-first forwarding on same-address read/write.
module regfile_2r1w_init
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              ready,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_sel;
  logic [ADDR_W-1:0] clear_idx;
  logic              usr_we, arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  logic [NUM_RD-1:0]             rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_word, rd_q;
  logic [NUM_RD-1:0]             rd_vld_q;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .ready     (ready),
    .clear_sel (clear_sel),
    .clear_idx (clear_idx)
  );

  // User writes to the hardwired zero entry vanish without a drop report.
  assign usr_we    = ready && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign arr_we    = clear_sel || usr_we;
  assign arr_waddr = clear_sel ? clear_idx : wr_addr;
  assign arr_wdata = clear_sel ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (arr_we) mem[arr_waddr] <= arr_wdata;
  end

  assign rd_en   = {rd_en_b, rd_en_a};
  assign rd_addr = {rd_addr_b, rd_addr_a};

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (usr_we && wr_addr == rd_addr[p]) rd_word[p] = wr_data;
`endif
      if (ZERO_REG != 0 && rd_addr[p] == '0) rd_word[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rd_vld_q <= '0;
      wr_drop  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_vld_q[p] <= ready && rd_en[p];
        if (ready && rd_en[p]) rd_q[p] <= rd_word[p];
      end
      wr_drop <= clear_sel && wr_en;
    end
  end

  assign rd_data_a  = rd_q[0];
  assign rd_data_b  = rd_q[1];
  assign rd_valid_a = rd_vld_q[0];
  assign rd_valid_b = rd_vld_q[1];

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Directed bench for regfile_2r1w_init: a plain instance and a ZERO_REG=1
// instance share stimulus; expected values are hand-computed constants.
module tb_regfile_2r1w_init;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, clear_req;
  logic        rd_en_a, rd_en_b, wr_en;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] wr_data;

  logic        ready, rd_valid_a, rd_valid_b, wr_drop;
  logic [15:0] rd_data_a, rd_data_b;
  logic        z_ready, z_valid_a, z_valid_b, z_drop;
  logic [15:0] z_data_a, z_data_b;

  int total = 0;
  int passed = 0;

  regfile_2r1w_init #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop)
  );

  regfile_2r1w_init #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(z_ready),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(z_data_a), .rd_valid_a(z_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(z_data_b), .rd_valid_b(z_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(z_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic        ea;
    logic [4:0]  aa;
    logic        eb;
    logic [4:0]  ab;
    logic [15:0] xa;
    logic        xva;
    logic [15:0] xb;
    logic        xvb;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    rd_en_a = 1'b0; rd_addr_a = '0;
    rd_en_b = 1'b0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({name, "_cycles"}, cnt, exp_cycles);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic low_ok;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();

    chk("rst_ready",   {31'd0, ready},      32'd0);
    chk("rst_data_a",  {16'd0, rd_data_a},  32'd0);
    chk("rst_data_b",  {16'd0, rd_data_b},  32'd0);
    chk("rst_valid",   {30'd0, rd_valid_a, rd_valid_b}, 32'd0);
    chk("rst_drop",    {31'd0, wr_drop},    32'd0);

    // Initial clear: ready low for exactly 32 edges after release.
    rst_n = 1'b1;
    low_ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k < 32 && ready) low_ok = 1'b0;
    end
    chk("init_ready_low_31", {31'd0, low_ok}, 32'd1);
    chk("init_ready_at_32",  {31'd0, ready},  32'd1);

    for (int i = 0; i < 32; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 5'(i);
      rd_en_b = 1'b1; rd_addr_b = 5'(31 - i);
      tick();
      chk("init_rd_a", {16'd0, rd_data_a}, 32'd0);
      chk("init_rd_b", {16'd0, rd_data_b}, 32'd0);
      chk("init_vld",  {30'd0, rd_valid_a, rd_valid_b}, 32'd3);
    end
    idle_inputs();

    vt[0] = '{1'b1, 5'd7,  16'hA5A5, 1'b0, 5'd0,  1'b0, 5'd0,  16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd7,  1'b1, 5'd7,  16'hA5A5, 1'b1, 16'hA5A5, 1'b1};
    vt[2] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd7,  1'b0, 5'd7,  16'hA5A5, 1'b0, 16'hA5A5, 1'b0};
    vt[3] = '{1'b1, 5'd3,  16'h0BAD, 1'b1, 5'd5,  1'b1, 5'd6,  16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[4] = '{1'b1, 5'd3,  16'h1234, 1'b1, 5'd3,  1'b1, 5'd7,
              BYP ? 16'h1234 : 16'h0BAD, 1'b1, 16'hA5A5, 1'b1};
    vt[5] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd3,  1'b1, 5'd3,  16'h1234, 1'b1, 16'h1234, 1'b1};
    vt[6] = '{1'b1, 5'd31, 16'hFFFF, 1'b0, 5'd3,  1'b1, 5'd31,
              16'h1234, 1'b0, BYP ? 16'hFFFF : 16'h0000, 1'b1};
    vt[7] = '{1'b1, 5'd0,  16'hBEEF, 1'b1, 5'd0,  1'b0, 5'd0,
              BYP ? 16'hBEEF : 16'h0000, 1'b1, BYP ? 16'hFFFF : 16'h0000, 1'b0};
    vt[8] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd0,  1'b1, 5'd31, 16'hBEEF, 1'b1, 16'hFFFF, 1'b1};

    for (int v = 0; v < 9; v++) begin
      wr_en = vt[v].we; wr_addr = vt[v].wa; wr_data = vt[v].wd;
      rd_en_a = vt[v].ea; rd_addr_a = vt[v].aa;
      rd_en_b = vt[v].eb; rd_addr_b = vt[v].ab;
      tick();
      chk($sformatf("vec%0d_data_a", v),  {16'd0, rd_data_a},  {16'd0, vt[v].xa});
      chk($sformatf("vec%0d_valid_a", v), {31'd0, rd_valid_a}, {31'd0, vt[v].xva});
      chk($sformatf("vec%0d_data_b", v),  {16'd0, rd_data_b},  {16'd0, vt[v].xb});
      chk($sformatf("vec%0d_valid_b", v), {31'd0, rd_valid_b}, {31'd0, vt[v].xvb});
      chk($sformatf("vec%0d_drop", v),    {31'd0, wr_drop},    32'd0);
    end
    idle_inputs();

    // Zero register: writes to entry 0 vanish silently on the ZERO_REG instance.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h1111;
    rd_en_a = 1'b1; rd_addr_a = 5'd0;
    tick();
    chk("zr_same_edge_main", {16'd0, rd_data_a}, {16'd0, BYP ? 16'h1111 : 16'hBEEF});
    chk("zr_same_edge_z",    {16'd0, z_data_a},  32'd0);
    chk("zr_valid_z",        {31'd0, z_valid_a}, 32'd1);
    chk("zr_drop_z",         {31'd0, z_drop},    32'd0);
    wr_en = 1'b0;
    tick();
    chk("zr_read_main", {16'd0, rd_data_a}, 32'h1111);
    chk("zr_read_z",    {16'd0, z_data_a},  32'd0);
    chk("zr_valid_z2",  {31'd0, z_valid_a}, 32'd1);
    idle_inputs();

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h5A5A;
    tick();
    idle_inputs();
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    chk("pre_clear_rd9", {16'd0, rd_data_a}, 32'h5A5A);
    idle_inputs();

    // Requested clear: writes dropped, reads ignored, 32-cycle walk.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_ready_low", {31'd0, ready}, 32'd0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'hFFFF;
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    chk("clr_drop",       {31'd0, wr_drop},    32'd1);
    chk("clr_rd_ignored", {31'd0, rd_valid_a}, 32'd0);
    chk("clr_rd_hold",    {16'd0, rd_data_a},  32'h5A5A);
    idle_inputs();
    tick();
    chk("clr_drop_pulse", {31'd0, wr_drop}, 32'd0);
    wait_ready("clr", 30);

    rd_en_a = 1'b1; rd_addr_a = 5'd4;
    rd_en_b = 1'b1; rd_addr_b = 5'd7;
    tick();
    chk("post_clr_rd4", {16'd0, rd_data_a}, 32'd0);
    chk("post_clr_rd7", {16'd0, rd_data_b}, 32'd0);
    idle_inputs();

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h5A5A;
    tick();
    idle_inputs();
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    chk("pre_abort_rd9", {16'd0, rd_data_a}, 32'h5A5A);
    idle_inputs();

    // Reset mid-clear at clear_idx=10: outputs clear at once, walk restarts.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_data_a", {16'd0, rd_data_a}, 32'd0);
    chk("abort_ready",  {31'd0, ready},     32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready("abort", 32);
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    chk("post_abort_rd9", {16'd0, rd_data_a}, 32'd0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
